// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared multi-cycle ALU.
// Latency: grant in IDLE at N, alu_start at N+1, done no earlier than N+4 (ALU final in first WAIT cycle).
// Backpressure: a requester holds req with stable operands until its done pulse; the losing requester simply waits.
//
// Ports:
//   clk, rst            single clock, asynchronous active-low reset
//   req*/op*/a*/b*      per-requester job request, opcode (00 add, 01 sub, 10 mul, 11 div) and operands
//   done0/done1         one-cycle completion pulse for the owning requester; res/err valid with it
//   res, err            job result (0 on timeout) and timeout flag, held until the next completion
//   busy, owner         arbiter not idle / index of the granted requester
//   alu_start/op/inbus  strobe, opcode and operand byte towards the shared ALU (a in ISSUE, b afterwards)
//   alu_final/outbus    ALU completion flag and result, only looked at while waiting for the ALU
module alu_arbiter #(
  parameter int TIMEOUT = 64  // WAIT cycles allowed before abort, 2..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [1:0]  op0,
  input  logic [1:0]  op1,
  input  logic [7:0]  a0,
  input  logic [7:0]  a1,
  input  logic [7:0]  b0,
  input  logic [7:0]  b1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] res,
  output logic        err,
  output logic        busy,
  output logic        owner,
  output logic        alu_start,
  output logic [1:0]  alu_op,
  output logic [7:0]  alu_inbus,
  input  logic        alu_final,
  input  logic [15:0] alu_outbus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ISSUE  = 3'd1;
  localparam logic [2:0] LOAD_B = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  // The counter holds the number of completed WAIT cycles, so the last
  // permitted WAIT cycle is the one that starts with TIMEOUT-1.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [2:0]  state_q;
  logic        owner_q;
  logic        last_q;      // requester served by the most recent job
  logic        last_vld_q;  // cleared by reset so requester 0 wins the first tie
  logic [1:0]  op_q;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [7:0]  cnt_q;
  logic [15:0] res_q;
  logic        err_q;
  logic        grant1;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign grant1 = req1 & (~req0 | (last_vld_q & ~last_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b0;
      last_vld_q <= 1'b0;
      op_q       <= 2'd0;
      a_q        <= 8'd0;
      b_q        <= 8'd0;
      cnt_q      <= 8'd0;
      res_q      <= 16'd0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Operands are captured here so later requester activity cannot
          // disturb the running job.
          if (req0 | req1) begin
            owner_q <= grant1;
            op_q    <= grant1 ? op1 : op0;
            a_q     <= grant1 ? a1 : a0;
            b_q     <= grant1 ? b1 : b0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= LOAD_B;
        end
        LOAD_B: begin
          cnt_q   <= 8'd0;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          // A final arriving in the last permitted cycle still counts as success.
          if (alu_final) begin
            res_q   <= alu_outbus;
            err_q   <= 1'b0;
            state_q <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            res_q   <= 16'h0000;
            err_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          last_q     <= owner_q;
          last_vld_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    alu_inbus = 8'd0;
    case (state_q)
      ISSUE:        alu_inbus = a_q;
      LOAD_B, WAIT: alu_inbus = b_q;
      default:      alu_inbus = 8'd0;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;
  assign alu_start = (state_q == ISSUE);
  assign alu_op    = op_q;
  assign done0     = (state_q == DONE) & ~owner_q;
  assign done1     = (state_q == DONE) &  owner_q;
  assign res       = res_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed jobs against a responding ALU, a cycle-timeline
// model of each job checked every cycle, and hand-computed literal expectations.
module tb_alu_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [1:0]  op0 = 2'd0;
  logic [1:0]  op1 = 2'd0;
  logic [7:0]  a0 = 8'd0;
  logic [7:0]  a1 = 8'd0;
  logic [7:0]  b0 = 8'd0;
  logic [7:0]  b1 = 8'd0;
  logic        done0;
  logic        done1;
  logic [15:0] res;
  logic        err;
  logic        busy;
  logic        owner;
  logic        alu_start;
  logic [1:0]  alu_op;
  logic [7:0]  alu_inbus;
  logic        alu_final;
  logic [15:0] alu_outbus = 16'd0;
  logic        r_final = 1'b0;
  logic        stray_final = 1'b0;

  assign alu_final = r_final | stray_final;

  alu_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .done0(done0), .done1(done1), .res(res), .err(err),
    .busy(busy), .owner(owner),
    .alu_start(alu_start), .alu_op(alu_op), .alu_inbus(alu_inbus),
    .alu_final(alu_final), .alu_outbus(alu_outbus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int prev = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] alu_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   return {8'd0, a} + {8'd0, b};
      2'b01:   return {8'd0, a} - {8'd0, b};
      2'b10:   return {8'd0, a} * {8'd0, b};
      default: return (b == 8'd0) ? 16'hFFFF : ({8'd0, a} / {8'd0, b});
    endcase
  endfunction

  // ---------------- job-timeline model ----------------
  // A job granted on the edge entering cycle S issues in S, loads b in S+1,
  // waits from S+2, and completes in the cycle after final is seen or after
  // TO waiting cycles.
  bit          m_job = 1'b0;
  bit          m_own = 1'b0;
  bit          m_last = 1'b0;
  bit          m_last_vld = 1'b0;
  logic [1:0]  m_op = 2'd0;
  logic [7:0]  m_a = 8'd0;
  logic [7:0]  m_b = 8'd0;
  logic [15:0] m_res = 16'd0;
  bit          m_err = 1'b0;
  int          m_start = 0;
  int          m_done = -1;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_job = 1'b0; m_last = 1'b0; m_last_vld = 1'b0;
      m_res = 16'd0; m_err = 1'b0; m_done = -1;
    end else begin
      cyc++;
      prev = cyc - 1;
      if (m_job) begin
        if (m_done >= 0) begin
          if (prev == m_done) begin
            m_job = 1'b0; m_last = m_own; m_last_vld = 1'b1;
          end
        end else if (prev >= m_start + 2) begin
          if (alu_final) begin
            m_done = cyc; m_res = alu_outbus; m_err = 1'b0;
          end else if (prev - m_start - 1 == TO) begin
            m_done = cyc; m_res = 16'h0000; m_err = 1'b1;
          end
        end
      end else if (req0 || req1) begin
        if (req0 && req1) m_own = m_last_vld ? !m_last : 1'b0;
        else              m_own = req1;
        if (m_own) begin m_op = op1; m_a = a1; m_b = b1; end
        else       begin m_op = op0; m_a = a0; m_b = b0; end
        m_job = 1'b1; m_start = cyc; m_done = -1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (rst) begin
      check("busy",      32'(busy),      32'(m_job));
      check("alu_start", 32'(alu_start), 32'(m_job && cyc == m_start));
      check("done0",     32'(done0),     32'(m_job && cyc == m_done && !m_own));
      check("done1",     32'(done1),     32'(m_job && cyc == m_done && m_own));
      check("res",       32'(res),       32'(m_res));
      check("err",       32'(err),       32'(m_err));
      if (m_job) check("owner", 32'(owner), 32'(m_own));
      if (m_job && (m_done < 0 || cyc < m_done)) begin
        check("alu_op",    32'(alu_op),    32'(m_op));
        check("alu_inbus", 32'(alu_inbus), (cyc == m_start) ? 32'(m_a) : 32'(m_b));
      end
    end
  end

  // ---------------- event recorder ----------------
  int start_cnt = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int done_q[$];

  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (alu_start) begin start_cnt++; start_cyc = cyc; end
      if (done0 || done1) begin done_cyc = cyc; done_q.push_back(done1 ? 1 : 0); end
    end
  end

  // ---------------- responding ALU ----------------
  // alu_lat = cycles from the start cycle to the cycle final is high; 0 = never.
  int         alu_lat = 3;
  int         r_cd = -1;
  bit         r_getb = 1'b0;
  logic [1:0] r_op = 2'd0;
  logic [7:0] r_a = 8'd0;
  logic [7:0] r_b = 8'd0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (alu_start) begin
        r_op = alu_op; r_a = alu_inbus; r_getb = 1'b1; r_cd = alu_lat;
      end else if (r_getb) begin
        r_b = alu_inbus; r_getb = 1'b0;
      end
    end
    @(posedge clk);
    #2;
    if (!rst) begin
      r_cd = -1; r_final = 1'b0; r_getb = 1'b0;
    end else if (r_cd > 0) begin
      r_cd--;
      r_final = (r_cd == 0);
      if (r_cd == 0) alu_outbus = alu_fn(r_op, r_a, r_b);
    end else begin
      r_final = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  int done_rd = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_req(input bit id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    if (id) begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    else    begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
  endtask

  task automatic drop_req(input bit id);
    if (id) req1 = 1'b0;
    else    req0 = 1'b0;
  endtask

  task automatic wait_done(output int id);
    id = -1;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (done_q.size() > done_rd) begin
        id = done_q[done_rd];
        done_rd++;
        return;
      end
    end
    n_chk++; n_err++;
    $display("FAIL wait_done: no done pulse within 100 cycles");
  endtask

  task automatic wait_start(input int base);
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (start_cnt > base) return;
    end
    n_chk++; n_err++;
    $display("FAIL wait_start: no alu_start within 50 cycles");
  endtask

  task automatic job(input bit id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                     input int lat, output int got, output int lat_c);
    alu_lat = lat;
    set_req(id, op, a, b);
    wait_done(got);
    drop_req(id);
    lat_c = done_cyc - start_cyc;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  32'(busy),      0);
    check({tag, "_owner"}, 32'(owner),     0);
    check({tag, "_done0"}, 32'(done0),     0);
    check({tag, "_done1"}, 32'(done1),     0);
    check({tag, "_err"},   32'(err),       0);
    check({tag, "_start"}, 32'(alu_start), 0);
    check({tag, "_res"},   32'(res),       0);
    check({tag, "_op"},    32'(alu_op),    0);
    check({tag, "_inbus"}, 32'(alu_inbus), 0);
  endtask

  // ---------------- directed sequence ----------------
  int g;
  int lc;
  int rc;
  int sb;

  initial begin
    #1 rst = 1'b0;
    tick(2);
    check_reset_outputs("rst0");
    rst = 1'b1;
    tick(2);

    // 5 + 3 with final three cycles after start
    rc = cyc; sb = start_cnt; alu_lat = 3;
    set_req(1'b0, 2'b00, 8'd5, 8'd3);
    wait_done(g);
    drop_req(1'b0);
    check("t1_id",      32'(g), 0);
    check("t1_res",     32'(res), 8);
    check("t1_err",     32'(err), 0);
    check("t1_issue",   32'(start_cyc), 32'(rc + 1));
    check("t1_nstart",  32'(start_cnt - sb), 1);
    check("t1_latency", 32'(done_cyc - start_cyc), 4);

    // minimum latency: final in first WAIT cycle, 7 * 6
    job(1'b1, 2'b10, 8'd7, 8'd6, 2, g, lc);
    check("tmin_id",      32'(g), 1);
    check("tmin_res",     32'(res), 42);
    check("tmin_latency", 32'(lc), 3);

    // final while idle is ignored, result held
    tick(1);
    stray_final = 1'b1;
    tick(3);
    check("stray_busy", 32'(busy), 0);
    stray_final = 1'b0;
    tick(1);
    check("hold_res", 32'(res), 42);
    check("hold_err", 32'(err), 0);

    // ALU never answers: abort after 8 WAIT cycles
    job(1'b0, 2'b01, 8'd50, 8'd8, 0, g, lc);
    check("to_err",     32'(err), 1);
    check("to_res",     32'(res), 0);
    check("to_latency", 32'(lc), TO + 2);
    job(1'b1, 2'b00, 8'd100, 8'd155, 4, g, lc);
    check("after_to_res", 32'(res), 255);
    check("after_to_err", 32'(err), 0);

    // final in the last WAIT cycle is a success
    job(1'b0, 2'b10, 8'd3, 8'd4, TO + 1, g, lc);
    check("edge_ok_res", 32'(res), 12);
    check("edge_ok_err", 32'(err), 0);
    check("edge_ok_lat", 32'(lc), TO + 2);
    // final one cycle too late
    job(1'b1, 2'b10, 8'd3, 8'd4, TO + 2, g, lc);
    check("edge_late_err", 32'(err), 1);
    check("edge_late_res", 32'(res), 0);
    // final during LOAD_B only is ignored
    job(1'b0, 2'b00, 8'd1, 8'd1, 1, g, lc);
    check("loadb_final_err", 32'(err), 1);
    check("loadb_final_lat", 32'(lc), TO + 2);

    // requester 1 changes everything and drops req while waiting
    alu_lat = 6; sb = start_cnt;
    set_req(1'b1, 2'b10, 8'd12, 8'd10);
    wait_start(sb);
    tick(3);
    req1 = 1'b0; op1 = 2'b00; a1 = 8'd99; b1 = 8'd77;
    tick(1);
    check("chg_inbus", 32'(alu_inbus), 10);
    check("chg_op",    32'(alu_op), 2);
    wait_done(g);
    check("chg_id",  32'(g), 1);
    check("chg_res", 32'(res), 120);
    check("chg_err", 32'(err), 0);

    // reset while waiting
    alu_lat = 0; sb = start_cnt;
    set_req(1'b0, 2'b10, 8'd20, 8'd20);
    wait_start(sb);
    tick(3);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    drop_req(1'b0);
    tick(2);
    rst = 1'b1;
    tick(3);
    check("rst_no_done", 32'(done_q.size() - done_rd), 0);
    job(1'b0, 2'b01, 8'd20, 8'd7, 3, g, lc);
    check("post_rst_id",  32'(g), 0);
    check("post_rst_res", 32'(res), 13);

    // requester 0 served last: a tie goes to 1, then 0
    alu_lat = 3;
    set_req(1'b0, 2'b00, 8'd1, 8'd2);
    set_req(1'b1, 2'b01, 8'd9, 8'd4);
    wait_done(g);
    drop_req(1'b1);
    check("rr_b_first",     32'(g), 1);
    check("rr_b_first_res", 32'(res), 5);
    wait_done(g);
    drop_req(1'b0);
    check("rr_b_second",     32'(g), 0);
    check("rr_b_second_res", 32'(res), 3);

    // fresh reset: both held high alternate starting with requester 0
    tick(1);
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
    set_req(1'b0, 2'b00, 8'd1, 8'd2);
    set_req(1'b1, 2'b01, 8'd9, 8'd4);
    for (int k = 0; k < 4; k++) begin
      wait_done(g);
      check("rr_a_order", 32'(g), 32'(k % 2));
      check("rr_a_res",   32'(res), (k % 2 == 1) ? 32'd5 : 32'd3);
    end
    drop_req(1'b0);
    drop_req(1'b1);
    tick(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum WAIT cycles before a job is aborted; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req0 / req1  input  1  requester 0/1 job request; held high with operands stable until its done pulse.
REQ-005 op0 / op1  input  2  requester opcode: 00 add, 01 sub, 10 mul, 11 div.
REQ-006 a0 / a1  input  8  requester first operand.
REQ-007 b0 / b1  input  8  requester second operand.
REQ-008 done0 / done1  output  1  one-cycle pulse: job of requester 0/1 finished; res and err valid in that cycle.
REQ-009 res  output  16  result of the finished job.
REQ-010 err  output  1  high with done pulse when the job timed out.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 owner  output  1  index of the requester currently granted.
REQ-013 alu_start  output  1  start strobe to the shared ALU.
REQ-014 alu_op  output  2  opcode to the ALU.
REQ-015 alu_inbus  output  8  operand byte to the ALU.
REQ-016 alu_final  input  1  ALU completion flag.
REQ-017 alu_outbus  input  16  ALU result.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, LOAD_B, WAIT, DONE.
REQ-019 IDLE: no request -> stay; any request -> latch winner's op/a/b into internal registers, set owner, go ISSUE next cycle.
REQ-020 Arbitration SHALL be round-robin: both requesting -> grant the requester not served last; after reset requester 0 has priority.
REQ-021 ISSUE (exactly 1 cycle): alu_start=1, alu_op=latched op, alu_inbus=latched a; -> LOAD_B.
REQ-022 LOAD_B (exactly 1 cycle): alu_start=0, alu_inbus=latched b; timeout counter cleared to 0; -> WAIT.
REQ-023 WAIT: alu_inbus=latched b, alu_op held; counter increments each cycle; alu_final=1 -> capture alu_outbus into res, err=0, -> DONE.
REQ-024 WAIT: counter reaches TIMEOUT with alu_final=0 -> res=16'h0000, err=1, -> DONE.
REQ-025 alu_final high in the same cycle the counter reaches TIMEOUT SHALL count as success (err=0).
REQ-026 DONE (exactly 1 cycle): done<owner>=1, update last-served pointer to owner, -> IDLE; new grant decided no earlier than the following IDLE cycle.
REQ-027 Minimum job latency: request seen in IDLE at cycle N, alu_start at N+1, done at earliest N+4 (alu_final high in first WAIT cycle).
REQ-028 Operand/op changes or req deassertion after grant SHALL NOT affect the running job; the job completes and still pulses done.
REQ-029 alu_final outside WAIT SHALL be ignored.
REQ-030 res and err SHALL hold their value until the next DONE.
REQ-031 done0 and done1 SHALL never be high in the same cycle; alu_start SHALL be high only in ISSUE.

Reset
REQ-032 rst low SHALL immediately force IDLE; busy, owner, done0, done1, err, alu_start = 0; res, alu_op, alu_inbus = 0; counter and last-served pointer cleared.
REQ-033 Reset mid-job SHALL abandon the job without a done pulse; requester resubmits after release.

Verification
REQ-034 req0, op0=00, a0=8'd5, b0=8'd3; ALU model asserts final 3 cycles after start with outbus=16'd8 -> done0 pulse, res=16'd8, err=0, alu_start high exactly 1 cycle.
REQ-035 req0 and req1 raised same cycle after reset -> requester 0 served first, then requester 1; repeat both -> order alternates 1 then 0.
REQ-036 TIMEOUT=8, ALU never asserts final -> done pulse 8 WAIT cycles after LOAD_B, err=1, res=16'h0000; next job runs normally.
REQ-037 req1 job, a1/b1/op1 changed and req1 dropped during WAIT -> ALU inputs unchanged, done1 still pulses with correct result.
REQ-038 rst low during WAIT -> outputs at reset values asynchronously, no done pulse; after release a fresh req0 completes normally.
